// File: rtl/k12a_io_pkg.sv
// Shared definitions for the K12A I/O blocks: edge-sense modes, GPIO register
// offsets and the edge-detect helper used by every GPIO port.
package k12a_io_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edgeMode_e;

  localparam logic [1:0] REG_OUT   = 2'd0;
  localparam logic [1:0] REG_IN    = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;
  localparam logic [1:0] REG_FLAGS = 2'd3;

  // Compares the current synchronised sample against the previous one.
  function automatic logic [7:0] edgeDetect(input edgeMode_e mode,
                                            input logic [7:0] cur,
                                            input logic [7:0] prev);
    case (mode)
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/k12a_gpio_port.sv
// One 8-bit GPIO port: output and mask registers, input synchroniser,
// edge detector and sticky write-1-to-clear edge flags.
module k12a_gpio_port
  import k12a_io_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter edgeMode_e EDGE_SEL    = EDGE_RISE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wrOut_i,
  input  logic       wrMask_i,
  input  logic       wrFlags_i,
  input  logic [7:0] wrData_i,
  input  logic       detectEn_i,
  input  logic [7:0] pins_i,
  output logic [7:0] out_o,
  output logic [7:0] in_o,
  output logic [7:0] mask_o,
  output logic [7:0] flags_o
);

  logic [SYNC_STAGES-1:0][7:0] syncChain_q, syncChain_d;
  logic [7:0] prevSample_q, prevSample_d;
  logic [7:0] outReg_q, outReg_d;
  logic [7:0] maskReg_q, maskReg_d;
  logic [7:0] flags_q, flags_d;
  logic [7:0] sample;
  logic [7:0] edges;
  logic [7:0] clearBits;

  assign sample = syncChain_q[SYNC_STAGES-1];

  // A new edge in the same cycle as a clear leaves the flag set.
  always_comb begin
    outReg_d     = wrOut_i  ? wrData_i : outReg_q;
    maskReg_d    = wrMask_i ? wrData_i : maskReg_q;
    syncChain_d  = {syncChain_q[SYNC_STAGES-2:0], pins_i};
    prevSample_d = sample;
    edges        = detectEn_i ? edgeDetect(EDGE_SEL, sample, prevSample_q) : 8'h00;
    clearBits    = wrFlags_i ? wrData_i : 8'h00;
    flags_d      = (flags_q & ~clearBits) | edges;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      syncChain_q  <= '0;
      prevSample_q <= 8'h00;
      outReg_q     <= 8'h00;
      maskReg_q    <= 8'h00;
      flags_q      <= 8'h00;
    end else begin
      syncChain_q  <= syncChain_d;
      prevSample_q <= prevSample_d;
      outReg_q     <= outReg_d;
      maskReg_q    <= maskReg_d;
      flags_q      <= flags_d;
    end
  end

  assign out_o   = outReg_q;
  assign in_o    = sample;
  assign mask_o  = maskReg_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/k12a_gpio_bank.sv
// Bank of NUM_PORTS GPIO ports on the K12A CPU bus: address decode, tri-state
// read mux, post-reset settle counter and the wake request.
module k12a_gpio_bank
  import k12a_io_pkg::*;
#(
  parameter  int NUM_PORTS   = 3,
  parameter  int SYNC_STAGES = 2,
  parameter  int EDGE_MODE   = 0,
  localparam int ADDR_WIDTH  = $clog2(NUM_PORTS) + 2
) (
  input  logic                   cpu_clock,
  input  logic                   reset_n,
  input  logic                   io_load_n,
  input  logic                   io_store_n,
  input  logic [ADDR_WIDTH-1:0]  io_addr,
  inout  wire  [7:0]             data_bus,
  output logic [NUM_PORTS*8-1:0] gpio_out,
  input  logic [NUM_PORTS*8-1:0] gpio_in,
  output logic                   wake
);

  localparam int        IDX_W       = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam edgeMode_e EDGE_SEL    = edgeMode_e'(EDGE_MODE[1:0]);
  localparam logic [2:0] SETTLE_LOAD = 3'(SYNC_STAGES + 1);

  logic [IDX_W-1:0] portIdx;
  logic [1:0]       offset;
  logic             portValid;
  logic             storeEn;
  logic             loadEn;
  logic             detectEn;
  logic [7:0]       readData;
  logic [2:0]       settle_q, settle_d;
  logic [7:0]       outVal   [NUM_PORTS];
  logic [7:0]       inVal    [NUM_PORTS];
  logic [7:0]       maskVal  [NUM_PORTS];
  logic [7:0]       flagsVal [NUM_PORTS];

  // A single-port bank has no port-index field in its address.
  if (ADDR_WIDTH > 2) begin : gIdx
    assign portIdx = io_addr[ADDR_WIDTH-1:2];
  end else begin : gIdxZero
    assign portIdx = '0;
  end

  assign offset    = io_addr[1:0];
  assign portValid = 32'(portIdx) < NUM_PORTS;
  assign storeEn   = !io_store_n && portValid;
  assign loadEn    = !io_load_n && io_store_n && portValid;

  // Synchronisers hold stale zeros right after reset, so edges are ignored
  // until they have flushed.
  always_comb begin
    settle_d = (settle_q != 3'd0) ? settle_q - 3'd1 : settle_q;
  end

  always_ff @(posedge cpu_clock) begin
    if (!reset_n) settle_q <= SETTLE_LOAD;
    else          settle_q <= settle_d;
  end

  assign detectEn = (settle_q == 3'd0);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    logic portSel;
    assign portSel = storeEn && (32'(portIdx) == p);

    k12a_gpio_port #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_SEL   (EDGE_SEL)
    ) uPort (
      .clk_i     (cpu_clock),
      .rst_ni    (reset_n),
      .wrOut_i   (portSel && (offset == REG_OUT)),
      .wrMask_i  (portSel && (offset == REG_MASK)),
      .wrFlags_i (portSel && (offset == REG_FLAGS)),
      .wrData_i  (data_bus),
      .detectEn_i(detectEn),
      .pins_i    (gpio_in[8*p +: 8]),
      .out_o     (outVal[p]),
      .in_o      (inVal[p]),
      .mask_o    (maskVal[p]),
      .flags_o   (flagsVal[p])
    );
  end

  always_comb begin
    readData = 8'h00;
    gpio_out = '0;
    wake     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gpio_out[8*p +: 8] = outVal[p];
      wake = wake | (|(flagsVal[p] & maskVal[p]));
      if (32'(portIdx) == p) begin
        case (offset)
          REG_OUT:  readData = outVal[p];
          REG_IN:   readData = inVal[p];
          REG_MASK: readData = maskVal[p];
          default:  readData = flagsVal[p];
        endcase
      end
    end
  end

  assign data_bus = loadEn ? readData : 8'hzz;

endmodule
